// File: rtl/booth_dot_accum.sv
// Saturating dot-product accumulator fed by a Booth multiplier's signed products.
// Collects up to LEN terms (or fewer, ending on in_last) and holds the result until downstream takes it.
module booth_dot_accum #(
  parameter int N      = 3,
  parameter int PROD_W = 2*N,
  parameter int LEN    = 4,
  parameter int ACC_W  = 8,
  parameter int CNT_W  = $clog2(LEN+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_terms,
  output logic              out_sat
);

  // Adder is wide enough for both operands plus one bit, so overflow past ACC_W is always visible.
  localparam int SUM_W = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((2**(ACC_W-1)) - 1);
  localparam logic signed [SUM_W-1:0] ACC_MIN = ~ACC_MAX;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_terms_q, out_terms_d;
  logic               out_sat_q, out_sat_d;

  logic signed [SUM_W-1:0] prod_ext;
  logic signed [SUM_W-1:0] acc_ext;
  logic signed [SUM_W-1:0] sum_ext;
  logic [ACC_W-1:0]        acc_new;
  logic                    sat_hit;
  logic                    last_term;

  always_comb begin
    prod_ext = {{(SUM_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
    acc_ext  = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    sum_ext  = prod_ext + acc_ext;
    sat_hit  = 1'b0;
    acc_new  = sum_ext[ACC_W-1:0];
    if (sum_ext > ACC_MAX) begin
      acc_new = ACC_MAX[ACC_W-1:0];
      sat_hit = 1'b1;
    end else if (sum_ext < ACC_MIN) begin
      acc_new = ACC_MIN[ACC_W-1:0];
      sat_hit = 1'b1;
    end
    last_term = in_last || (cnt_q == CNT_W'(LEN-1));
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_terms_d = out_terms_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      ACCUM: begin
        // clear beats a simultaneous accept: the term is dropped.
        if (clear) begin
          acc_d = '0;
          cnt_d = '0;
          sat_d = 1'b0;
        end else if (in_valid) begin
          if (last_term) begin
            out_sum_d   = acc_new;
            out_terms_d = cnt_q + 1'b1;
            out_sat_d   = sat_q | sat_hit;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            sat_d       = 1'b0;
            state_d     = HOLD;
          end else begin
            acc_d = acc_new;
            cnt_d = cnt_q + 1'b1;
            sat_d = sat_q | sat_hit;
          end
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_terms_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_terms_q <= out_terms_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_terms = out_terms_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_booth_dot_accum.sv
// Directed bench for booth_dot_accum: a default instance (ACC_W=8) and a narrow one (ACC_W=6)
// for saturation, both sharing clock and reset.
module tb_booth_dot_accum;

  logic       clk;
  logic       rst_n;

  logic       in_valid_a, in_ready_a, in_last_a, clear_a, out_valid_a, out_ready_a, out_sat_a;
  logic [5:0] in_prod_a;
  logic [7:0] out_sum_a;
  logic [2:0] out_terms_a;

  logic       in_valid_b, in_ready_b, in_last_b, clear_b, out_valid_b, out_ready_b, out_sat_b;
  logic [5:0] in_prod_b;
  logic [5:0] out_sum_b;
  logic [2:0] out_terms_b;

  int checks;
  int failures;

  booth_dot_accum dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_prod(in_prod_a), .in_last(in_last_a),
    .clear(clear_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_sum(out_sum_a),
    .out_terms(out_terms_a), .out_sat(out_sat_a)
  );

  booth_dot_accum #(.ACC_W(6)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_prod(in_prod_b), .in_last(in_last_b),
    .clear(clear_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_sum(out_sum_b),
    .out_terms(out_terms_b), .out_sat(out_sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int p, input logic last);
    in_valid_a = 1'b1;
    in_prod_a  = 6'(p);
    in_last_a  = last;
    tick();
    in_valid_a = 1'b0;
    in_last_a  = 1'b0;
  endtask

  task automatic send_b(input int p, input logic last);
    in_valid_b = 1'b1;
    in_prod_b  = 6'(p);
    in_last_b  = last;
    tick();
    in_valid_b = 1'b0;
    in_last_b  = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid_a !== 1'b0 || out_sum_a !== 8'd0 || out_terms_a !== 3'd0 || out_sat_a !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_a_outputs: got valid=%0b sum=%0d terms=%0d sat=%0b expected all 0",
               out_valid_a, out_sum_a, out_terms_a, out_sat_a);
    end
    checks++;
    if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_in_ready: got a=%0b b=%0b expected 1", in_ready_a, in_ready_b);
    end
    checks++;
    if (out_valid_b !== 1'b0 || out_sum_b !== 6'd0 || out_terms_b !== 3'd0 || out_sat_b !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_b_outputs: got valid=%0b sum=%0d terms=%0d sat=%0b expected all 0",
               out_valid_b, out_sum_b, out_terms_b, out_sat_b);
    end
  endtask

  task automatic test_basic();
    out_ready_a = 1'b1;
    send_a(9, 1'b0);
    send_a(16, 1'b0);
    send_a(-12, 1'b0);
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_mid_vector: got valid=%0b ready=%0b expected valid=0 ready=1",
               out_valid_a, in_ready_a);
    end
    send_a(-2, 1'b0);
    checks++;
    if (out_valid_a !== 1'b1 || out_sum_a !== 8'(11) || out_terms_a !== 3'd4 || out_sat_a !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_result: got valid=%0b sum=%0d terms=%0d sat=%0b expected 1 11 4 0",
               out_valid_a, $signed(out_sum_a), out_terms_a, out_sat_a);
    end
    checks++;
    if (in_ready_a !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_hold_ready: got %0b expected 0", in_ready_a);
    end
    tick();
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_bubble: got valid=%0b ready=%0b expected valid=0 ready=1",
               out_valid_a, in_ready_a);
    end
  endtask

  task automatic test_backpressure();
    out_ready_a = 1'b0;
    send_a(9, 1'b0);
    send_a(16, 1'b0);
    send_a(-12, 1'b0);
    send_a(-2, 1'b0);
    // A stray term offered while holding must not be taken.
    in_valid_a = 1'b1;
    in_prod_a  = 6'(7);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid_a !== 1'b1 || out_sum_a !== 8'(11) || in_ready_a !== 1'b0) begin
        failures++;
        $display("[TB] FAIL backpressure_hold[%0d]: got valid=%0b sum=%0d ready=%0b expected 1 11 0",
                 i, out_valid_a, $signed(out_sum_a), in_ready_a);
      end
      tick();
    end
    in_valid_a  = 1'b0;
    out_ready_a = 1'b1;
    tick();
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      failures++;
      $display("[TB] FAIL backpressure_release: got valid=%0b ready=%0b expected 0 1",
               out_valid_a, in_ready_a);
    end
  endtask

  task automatic test_early_last();
    out_ready_a = 1'b1;
    send_a(16, 1'b0);
    send_a(16, 1'b1);
    checks++;
    if (out_valid_a !== 1'b1 || out_sum_a !== 8'(32) || out_terms_a !== 3'd2 || out_sat_a !== 1'b0) begin
      failures++;
      $display("[TB] FAIL early_last: got valid=%0b sum=%0d terms=%0d sat=%0b expected 1 32 2 0",
               out_valid_a, $signed(out_sum_a), out_terms_a, out_sat_a);
    end
    tick();
    for (int i = 0; i < 4; i++) send_a(1, 1'b0);
    checks++;
    if (out_valid_a !== 1'b1 || out_sum_a !== 8'(4) || out_terms_a !== 3'd4) begin
      failures++;
      $display("[TB] FAIL no_carry_over: got valid=%0b sum=%0d terms=%0d expected 1 4 4",
               out_valid_a, $signed(out_sum_a), out_terms_a);
    end
    tick();
  endtask

  task automatic test_saturation();
    out_ready_b = 1'b1;
    send_b(16, 1'b0);
    send_b(16, 1'b0);
    send_b(16, 1'b1);
    checks++;
    if (out_valid_b !== 1'b1 || out_sum_b !== 6'(31) || out_sat_b !== 1'b1 || out_terms_b !== 3'd3) begin
      failures++;
      $display("[TB] FAIL sat_positive: got valid=%0b sum=%0d terms=%0d sat=%0b expected 1 31 3 1",
               out_valid_b, $signed(out_sum_b), out_terms_b, out_sat_b);
    end
    tick();
    send_b(-12, 1'b0);
    send_b(-12, 1'b0);
    send_b(-12, 1'b1);
    checks++;
    if (out_valid_b !== 1'b1 || out_sum_b !== 6'(-32) || out_sat_b !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sat_negative: got valid=%0b sum=%0d sat=%0b expected 1 -32 1",
               out_valid_b, $signed(out_sum_b), out_sat_b);
    end
    tick();
    send_b(16, 1'b0);
    send_b(-12, 1'b1);
    checks++;
    if (out_valid_b !== 1'b1 || out_sum_b !== 6'(4) || out_sat_b !== 1'b0 || out_terms_b !== 3'd2) begin
      failures++;
      $display("[TB] FAIL sat_none: got valid=%0b sum=%0d terms=%0d sat=%0b expected 1 4 2 0",
               out_valid_b, $signed(out_sum_b), out_terms_b, out_sat_b);
    end
    tick();
  endtask

  task automatic test_clear();
    out_ready_a = 1'b0;
    send_a(9, 1'b0);
    send_a(9, 1'b0);
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    for (int i = 0; i < 4; i++) send_a(1, 1'b0);
    checks++;
    if (out_valid_a !== 1'b1 || out_sum_a !== 8'(4) || out_terms_a !== 3'd4) begin
      failures++;
      $display("[TB] FAIL clear_flush: got valid=%0b sum=%0d terms=%0d expected 1 4 4",
               out_valid_a, $signed(out_sum_a), out_terms_a);
    end
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    checks++;
    if (out_valid_a !== 1'b1 || out_sum_a !== 8'(4) || out_terms_a !== 3'd4 || in_ready_a !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clear_in_hold: got valid=%0b sum=%0d terms=%0d ready=%0b expected 1 4 4 0",
               out_valid_a, $signed(out_sum_a), out_terms_a, in_ready_a);
    end
    out_ready_a = 1'b1;
    tick();
    checks++;
    if (out_valid_a !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clear_release: got valid=%0b expected 0", out_valid_a);
    end
  endtask

  task automatic test_async_reset();
    send_a(9, 1'b0);
    send_a(9, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid_a !== 1'b0 || out_sum_a !== 8'd0 || out_terms_a !== 3'd0 || out_sat_a !== 1'b0
        || in_ready_a !== 1'b1) begin
      failures++;
      $display("[TB] FAIL async_reset: got valid=%0b sum=%0d terms=%0d sat=%0b ready=%0b expected 0 0 0 0 1",
               out_valid_a, out_sum_a, out_terms_a, out_sat_a, in_ready_a);
    end
    #2;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send_a(3, 1'b0);
    checks++;
    if (out_valid_a !== 1'b1 || out_sum_a !== 8'(12) || out_terms_a !== 3'd4) begin
      failures++;
      $display("[TB] FAIL after_reset_vector: got valid=%0b sum=%0d terms=%0d expected 1 12 4",
               out_valid_a, $signed(out_sum_a), out_terms_a);
    end
    tick();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b1;
    in_valid_a  = 1'b0; in_prod_a = '0; in_last_a = 1'b0; clear_a = 1'b0; out_ready_a = 1'b0;
    in_valid_b  = 1'b0; in_prod_b = '0; in_last_b = 1'b0; clear_b = 1'b0; out_ready_b = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    test_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_backpressure();
    test_early_last();
    test_saturation();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_dot_accum.md
Name: booth_dot_accum

Overview:
- Downstream consumer of the combinational Booth multiplier's signed product.
- Accepts one product per cycle over a valid/ready handshake and accumulates LEN products, or fewer if terminated early by in_last, into a signed saturating sum.
- Presents the finished dot-product on a registered valid/ready output port.
- Holds back new input while a result is waiting.

Parameters:
- N, 3, multiplier operand width; matches the multiplier's operand size.
- PROD_W, 2*N, width of the incoming signed product.
- LEN, 4, maximum number of terms per dot-product (>=1).
- ACC_W, 8, accumulator/result width; signed two's complement, saturating.
- CNT_W, $clog2(LEN+1), width of the term counter and out_terms.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, in_prod and in_last are valid.
- in_ready, output, 1, block can accept a term this cycle.
- in_prod, input, PROD_W, signed product from the multiplier.
- in_last, input, 1, this term ends the current vector.
- clear, input, 1, synchronous flush of the partial accumulation.
- out_valid, output, 1, out_sum, out_terms and out_sat are valid.
- out_ready, input, 1, downstream accepts the result.
- out_sum, output, ACC_W, signed dot-product result.
- out_terms, output, CNT_W, number of terms accumulated into out_sum.
- out_sat, output, 1, saturation occurred at least once in this vector.

Behaviour:
- Reset: rst_n low asynchronously forces the following, and any in-flight vector is discarded:
  - state=ACCUM
  - acc=0, cnt=0, sat=0
  - out_valid=0, out_sum=0, out_terms=0, out_sat=0
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- States:
  - ACCUM: in_ready=1.
  - HOLD: in_ready=0.
  - in_ready is a pure decode of the state register; no combinational path from out_ready.
- Accept: a term is accepted when in_valid && in_ready.
  - Sign-extend in_prod to ACC_W+1 bits and add to sign-extended acc.
  - If result > 2^(ACC_W-1)-1, clamp to the maximum and set sat.
  - If result < -2^(ACC_W-1), clamp to the minimum and set sat.
  - cnt increments on every accept.
  - sat is sticky within a vector.
- Vector end: an accept ends the vector when in_last=1 or cnt==LEN-1. On the next edge:
  - out_sum=new clamped acc, out_terms=cnt+1, out_sat=new sat, out_valid=1.
  - acc, cnt and sat reset to 0.
  - state becomes HOLD.
  - Latency: result is visible the cycle after the final accept.
- HOLD:
  - out_sum, out_terms and out_sat are stable while out_valid=1.
  - When out_valid && out_ready: out_valid goes to 0 and state returns to ACCUM on the next edge.
  - Exactly one bubble cycle between vectors.
  - out_ready while out_valid=0 is ignored.
- clear:
  - In ACCUM: acc, cnt and sat go to 0 on the next edge.
  - If clear and an accept occur in the same cycle, clear wins and the term is dropped. in_ready stays 1, so the upstream must not count it as consumed; integration guarantees clear is not asserted with in_valid.
  - In HOLD: clear is ignored, so the pending result is never corrupted.
- LEN==1: every accept ends the vector.
- in_valid without in_ready: no state change; in_prod is ignored.
- All outputs are registered except in_ready, which is a state decode.

Test Plan:
- Products 9, 16, -12, -2 on consecutive cycles, in_last=0, out_ready=1 → one cycle after the 4th accept: out_valid=1, out_sum=8'sd11, out_terms=4, out_sat=0; in_ready=0 for exactly the HOLD cycle.
- Same vector with out_ready=0 for 5 cycles → out_valid stays 1, out_sum stays 11, in_ready stays 0. Raise out_ready → out_valid=0 and in_ready=1 on the next edge.
- Products 16, then 16 with in_last=1 → out_sum=32, out_terms=2. The next vector 1, 1, 1, 1 → out_sum=4, out_terms=4, with no carry-over from the prior vector.
- ACC_W=6 override:
  - Products 16, 16, 16 with last → out_sum=31, out_sat=1.
  - Products -12, -12, -12 with last → out_sum=-32, out_sat=1.
  - Products 16, -12 with last → out_sum=4, out_sat=0.
- Accept 9 and 9, pulse clear with in_valid=0, then 1, 1, 1, 1 → out_sum=4, out_terms=4. clear asserted during HOLD → out_sum is unchanged.
- Accept 9 and 9, then drop rst_n mid-cycle, asynchronously → all outputs 0 immediately. Release, then send 3, 3, 3, 3 → out_sum=12, out_terms=4.
